// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: EX-stage redirect controls, imem load port, and IF/ID outputs.
// master = datapath/loader side, slave = the fetch stage.
interface instruction_fetch_if #(
  parameter int ADDR_W = 10
);
  logic              stall;
  logic              branch_taken;
  logic              jump;
  logic              jump_reg;
  logic [31:0]       seOut;
  logic [25:0]       jump_index;
  logic [31:0]       reg_Da;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       Instructions;
  logic [31:0]       pc_if;
  logic [31:0]       pc_plus4;
  logic [15:0]       redirect_count;
  logic [15:0]       stall_count;

  modport master (
    output stall, branch_taken, jump, jump_reg, seOut, jump_index, reg_Da,
           imem_we, imem_waddr, imem_wdata,
    input  Instructions, pc_if, pc_plus4, redirect_count, stall_count
  );

  modport slave (
    input  stall, branch_taken, jump, jump_reg, seOut, jump_index, reg_Da,
           imem_we, imem_waddr, imem_wdata,
    output Instructions, pc_if, pc_plus4, redirect_count, stall_count
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch: PC, word-addressed imem, IF->ID->EX PC shadow pipeline
// for EX-resolved redirects, fetch squash and saturating debug counters.
module instruction_fetch #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.slave  bus
);

  logic [31:0] imem [2**ADDR_W];

  logic [31:0] pcIf_q, pcIf_d;
  logic [31:0] pcId_q;
  logic [31:0] pcEx_q;
  logic [15:0] redirectCount_q, redirectCount_d;
  logic [15:0] stallCount_q, stallCount_d;

  logic        redirect;
  logic        advance;
  logic [31:0] pcExPlus4;
  logic        unusedDaBits;

  assign redirect     = bus.jump_reg | bus.jump | bus.branch_taken;
  assign advance      = redirect | ~bus.stall;
  assign pcExPlus4    = pcEx_q + 32'd4;
  assign unusedDaBits = ^bus.reg_Da[1:0];

  // Branch/jump targets come from the EX instruction's own PC, not the fetch PC
  always_comb begin
    pcIf_d = pcIf_q + 32'd4;
    if (bus.jump_reg) begin
      pcIf_d = {bus.reg_Da[31:2], 2'b00};
    end else if (bus.jump) begin
      pcIf_d = {pcExPlus4[31:28], bus.jump_index, 2'b00};
    end else if (bus.branch_taken) begin
      pcIf_d = pcExPlus4 + (bus.seOut << 2);
    end else if (bus.stall) begin
      pcIf_d = pcIf_q;
    end
  end

  always_comb begin
    redirectCount_d = redirectCount_q;
    stallCount_d    = stallCount_q;
    if (redirect && (redirectCount_q != 16'hFFFF)) begin
      redirectCount_d = redirectCount_q + 16'd1;
    end
    if (bus.stall && !redirect && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcIf_q          <= RESET_PC;
      pcId_q          <= RESET_PC;
      pcEx_q          <= RESET_PC;
      redirectCount_q <= 16'd0;
      stallCount_q    <= 16'd0;
    end else begin
      pcIf_q          <= pcIf_d;
      redirectCount_q <= redirectCount_d;
      stallCount_q    <= stallCount_d;
      if (advance) begin
        pcEx_q <= pcId_q;
        pcId_q <= pcIf_q;
      end
    end
  end

  // Instruction storage survives reset so a program can be preloaded under reset
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  assign bus.Instructions   = redirect ? 32'h0000_0000 : imem[pcIf_q[ADDR_W+1:2]];
  assign bus.pc_if          = pcIf_q;
  assign bus.pc_plus4       = pcIf_q + 32'd4;
  assign bus.redirect_count = redirectCount_q;
  assign bus.stall_count    = stallCount_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch with a behavioural
// reference model plus directed scenarios pinned by literal expectations.
module tb_instruction_fetch;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2**ADDR_W;

  logic clk;
  logic rst;
  logic checkEn;
  int   checks;
  int   errors;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) bus();

  instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mImem [DEPTH];
  logic [31:0] mPcIf, mPcId, mPcEx;
  int          mRedirects, mStalls;

  function automatic logic [31:0] modelNextPc();
    if (bus.jump_reg)     return bus.reg_Da & 32'hFFFF_FFFC;
    if (bus.jump)         return ((mPcEx + 32'd4) & 32'hF000_0000) | (32'(bus.jump_index) * 32'd4);
    if (bus.branch_taken) return mPcEx + 32'd4 + bus.seOut * 32'd4;
    if (bus.stall)        return mPcIf;
    return mPcIf + 32'd4;
  endfunction

  function automatic bit modelRedirect();
    return bus.jump_reg || bus.jump || bus.branch_taken;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_we) mImem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPcIf      <= 32'h0;
      mPcId      <= 32'h0;
      mPcEx      <= 32'h0;
      mRedirects <= 0;
      mStalls    <= 0;
    end else begin
      mPcIf <= modelNextPc();
      if (modelRedirect() || !bus.stall) begin
        mPcId <= mPcIf;
        mPcEx <= mPcId;
      end
      if (modelRedirect()) mRedirects <= (mRedirects < 65535) ? mRedirects + 1 : 65535;
      else if (bus.stall)  mStalls    <= (mStalls < 65535) ? mStalls + 1 : 65535;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("Instructions", bus.Instructions,
                  modelRedirect() ? 32'h0 : mImem[mPcIf[ADDR_W+1:2]]);
      checkOutput("pc_if", bus.pc_if, mPcIf);
      checkOutput("pc_plus4", bus.pc_plus4, mPcIf + 32'd4);
      checkOutput("redirect_count", {16'h0, bus.redirect_count}, 32'(mRedirects));
      checkOutput("stall_count", {16'h0, bus.stall_count}, 32'(mStalls));
    end
  end

  task automatic applyStimulus(input logic st, input logic br, input logic j, input logic jr,
                               input logic [31:0] se, input logic [25:0] ji, input logic [31:0] da);
    @(posedge clk);
    #1;
    bus.stall        = st;
    bus.branch_taken = br;
    bus.jump         = j;
    bus.jump_reg     = jr;
    bus.seOut        = se;
    bus.jump_index   = ji;
    bus.reg_Da       = da;
    bus.imem_we      = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
  endtask

  logic [31:0] seRaw;

  initial begin
    checks  = 0;
    errors  = 0;
    checkEn = 1'b0;
    rst     = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.jump_reg = 1'b0;
    bus.seOut = 32'h0; bus.jump_index = 26'h0; bus.reg_Da = 32'h0;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'h0;

    // Preload the whole memory under reset; the first four words form the program
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk);
      #1;
      bus.imem_we    = 1'b1;
      bus.imem_waddr = a[ADDR_W-1:0];
      bus.imem_wdata = (a < 4) ? 32'h11 * 32'(a + 1) : $urandom;
    end
    @(posedge clk);
    #1;
    bus.imem_we = 1'b0;
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset pc_if", bus.pc_if, 32'h0);
    checkOutput("reset Instructions", bus.Instructions, 32'h11);
    checkOutput("reset redirect_count", {16'h0, bus.redirect_count}, 32'h0);
    checkOutput("reset stall_count", {16'h0, bus.stall_count}, 32'h0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("release pc_if", bus.pc_if, 32'h0);

    // Sequential fetch
    idle();
    checkOutput("seq pc 4", bus.pc_if, 32'h4);
    checkOutput("seq instr 22", bus.Instructions, 32'h22);
    idle();
    checkOutput("seq pc 8", bus.pc_if, 32'h8);
    checkOutput("seq instr 33", bus.Instructions, 32'h33);
    idle();
    checkOutput("seq pc C", bus.pc_if, 32'hC);
    checkOutput("seq instr 44", bus.Instructions, 32'h44);

    // Branch from PC 0x8 now in EX, offset 3 words
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 26'h0, 32'h0);
    checkOutput("branch cycle pc", bus.pc_if, 32'h10);
    checkOutput("branch squash", bus.Instructions, 32'h0);

    // All three redirect sources at once: JR must win
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 26'h3FF_FFFF, 32'h0000_0043);
    checkOutput("branch target", bus.pc_if, 32'h18);
    checkOutput("branch redirect_count", {16'h0, bus.redirect_count}, 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h4000_0010);
    checkOutput("JR priority target", bus.pc_if, 32'h40);
    checkOutput("JR priority count", {16'h0, bus.redirect_count}, 32'd2);

    idle();
    checkOutput("JR far target", bus.pc_if, 32'h4000_0010);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h000_0100, 32'h0);
    checkOutput("jump cycle pc", bus.pc_if, 32'h4000_0018);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0);
    checkOutput("jump target", bus.pc_if, 32'h4000_0400);
    checkOutput("jump redirect_count", {16'h0, bus.redirect_count}, 32'd4);

    // Back at 0, run to 0xC and stall three cycles
    idle();
    checkOutput("JR zero target", bus.pc_if, 32'h0);
    idle();
    idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("stall pc C", bus.pc_if, 32'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("stall pc held", bus.pc_if, 32'hC);
    checkOutput("stall instr held", bus.Instructions, 32'h44);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 26'h0, 32'h0);
    checkOutput("stall_count 3", {16'h0, bus.stall_count}, 32'd3);
    idle();
    checkOutput("stall+branch target", bus.pc_if, 32'h10);
    checkOutput("stall+branch stall_count", {16'h0, bus.stall_count}, 32'd3);
    checkOutput("stall+branch redirect_count", {16'h0, bus.redirect_count}, 32'd6);

    // Asynchronous reset with a redirect pending at pc 0x20
    idle();
    idle();
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h100);
    checkOutput("pre-reset pc", bus.pc_if, 32'h20);
    rst = 1'b1;
    #1;
    checkOutput("async reset pc", bus.pc_if, 32'h0);
    checkOutput("async reset redirect_count", {16'h0, bus.redirect_count}, 32'h0);
    checkOutput("async reset stall_count", {16'h0, bus.stall_count}, 32'h0);
    bus.jump_reg = 1'b0;
    #1;
    checkOutput("reset Instructions again", bus.Instructions, 32'h11);

    // Randomized traffic including memory writes and occasional resets
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      rst              = ($urandom_range(0, 63) == 0);
      bus.stall        = ($urandom_range(0, 3) == 0);
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      bus.jump         = ($urandom_range(0, 19) == 0);
      bus.jump_reg     = ($urandom_range(0, 19) == 0);
      seRaw            = $urandom_range(0, 31);
      bus.seOut        = seRaw - 32'd16;
      bus.jump_index   = 26'($urandom);
      bus.reg_Da       = $urandom;
      bus.imem_we      = ($urandom_range(0, 3) == 0);
      bus.imem_waddr   = (i % 8 == 0) ? dut.pcIf_q[ADDR_W+1:2] : ADDR_W'($urandom);
      bus.imem_wdata   = $urandom;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.imem_we = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.jump_reg = 1'b0;

    // Saturate redirect_count with back-to-back JR redirects
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.jump_reg = 1'b1;
    bus.reg_Da   = 32'h0;
    for (int i = 1; i <= 65535; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0);
    end
    checkOutput("redirect_count saturated", {16'h0, bus.redirect_count}, 32'hFFFF);
    idle();
    checkOutput("redirect_count stays saturated", {16'h0, bus.redirect_count}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
